// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU request arbiter.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int OPC_W = 4;
    localparam int DAT_W = 32;
    localparam int SRB_W = 5;
    localparam int SRC_W = 3;

    localparam logic [OPC_W-1:0] OP_MUL = 4'b0010;

    typedef struct packed {
        logic [OPC_W-1:0] opc;
        logic [DAT_W-1:0] in1;
        logic [DAT_W-1:0] in2;
        logic [SRB_W-1:0] srb;
        logic [SRC_W-1:0] src;
    } alu_op_t;

endpackage

// File: rtl/alu_req_arbiter_arb_pick.sv
// One-hot grant selection among valid requesters.
// ALU_ARB_RR_EN selects round-robin from ptr_i+1; otherwise lowest index wins.
module arb_pick #(
    parameter int NREQ  = 2,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  valid_i,
`ifdef ALU_ARB_RR_EN
    input  logic [PTR_W-1:0] ptr_i,
`endif
    output logic [NREQ-1:0]  grant_o
);

`ifdef ALU_ARB_RR_EN
    logic [PTR_W-1:0] idx;
    logic             found;

    // Search order starts just after the last winner and wraps.
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = PTR_W'((int'(ptr_i) + k) % NREQ);
            if (!found && valid_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end
`else
    logic found;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && valid_i[i]) begin
                grant_o[i] = 1'b1;
                found      = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one combinational ALU among NREQ valid/ready requesters: arbitrate, hold
// operands ALU_LAT cycles, return the captured result. ALU_ARB_RR_EN enables round-robin.
module alu_req_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int ALU_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [OPC_W*NREQ-1:0] req_opcode,
    input  logic [DAT_W*NREQ-1:0] req_in1,
    input  logic [DAT_W*NREQ-1:0] req_in2,
    input  logic [SRB_W*NREQ-1:0] req_sr_bit,
    input  logic [SRC_W*NREQ-1:0] req_sr_cont,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [DAT_W-1:0]      rsp_data,
    output logic [OPC_W-1:0]      alu_opcode,
    output logic [DAT_W-1:0]      alu_in1,
    output logic [DAT_W-1:0]      alu_in2,
    output logic [SRB_W-1:0]      alu_sr_bit,
    output logic [SRC_W-1:0]      alu_sr_cont,
    input  logic [DAT_W-1:0]      alu_out,
    output logic                  busy
);

    localparam int PTR_W = $clog2(NREQ);
    localparam int CNT_W = 4;

    state_t           state_q;
    logic [PTR_W-1:0] g_q, g_d;
    logic [CNT_W-1:0] cnt_q;
    alu_op_t          op_q, op_d;
    logic [DAT_W-1:0] rsp_data_q;
    logic [NREQ-1:0]  rsp_valid_q;
    logic             busy_q;
    logic [NREQ-1:0]  grant;

`ifdef ALU_ARB_RR_EN
    logic [PTR_W-1:0] ptr_q;
`endif

    arb_pick #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick (
        .valid_i (req_valid),
`ifdef ALU_ARB_RR_EN
        .ptr_i   (ptr_q),
`endif
        .grant_o (grant)
    );

    // Gated by rst_n so no requester sees an accept while reset is asserted.
    assign req_ready = (state_q == IDLE && rst_n) ? grant : '0;

    always_comb begin
        g_d = '0;
        for (int i = 0; i < NREQ; i++)
            if (grant[i]) g_d = PTR_W'(i);
    end

    always_comb begin
        op_d.opc = req_opcode [int'(g_d)*OPC_W +: OPC_W];
        op_d.in1 = req_in1    [int'(g_d)*DAT_W +: DAT_W];
        op_d.in2 = req_in2    [int'(g_d)*DAT_W +: DAT_W];
        op_d.srb = req_sr_bit [int'(g_d)*SRB_W +: SRB_W];
        op_d.src = req_sr_cont[int'(g_d)*SRC_W +: SRC_W];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            g_q         <= '0;
            cnt_q       <= '0;
            op_q        <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
`ifdef ALU_ARB_RR_EN
            ptr_q       <= PTR_W'(NREQ-1);
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (|(req_valid & req_ready)) begin
                        op_q    <= op_d;
                        g_q     <= g_d;
                        cnt_q   <= CNT_W'(ALU_LAT-1);
                        busy_q  <= 1'b1;
                        state_q <= EXEC;
`ifdef ALU_ARB_RR_EN
                        ptr_q   <= g_d;
`endif
                    end
                end
                EXEC: begin
                    if (cnt_q == '0) begin
                        rsp_data_q  <= alu_out;
                        rsp_valid_q <= NREQ'(1) << g_q;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready[g_q]) begin
                        rsp_valid_q <= '0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign alu_opcode  = op_q.opc;
    assign alu_in1     = op_q.in1;
    assign alu_in2     = op_q.in2;
    assign alu_sr_bit  = op_q.srb;
    assign alu_sr_cont = op_q.src;
    assign busy        = busy_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Randomised bench for alu_req_arbiter against a transaction-level model, with directed
// literal checks; a second instance runs with ALU_LAT=4.
module tb_alu_req_arbiter;
    import alu_arb_pkg::*;

    localparam int NREQ = 2;
    localparam int LAT  = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [NREQ-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
    logic [4*NREQ-1:0] req_opcode;
    logic [32*NREQ-1:0] req_in1, req_in2;
    logic [5*NREQ-1:0] req_sr_bit;
    logic [3*NREQ-1:0] req_sr_cont;
    logic [31:0]       rsp_data, alu_in1, alu_in2, alu_out;
    logic [3:0]        alu_opcode;
    logic [4:0]        alu_sr_bit;
    logic [2:0]        alu_sr_cont;
    logic              busy;

    logic              d4_rst_n;
    logic [1:0]        d4_req_valid, d4_req_ready, d4_rsp_valid, d4_rsp_ready;
    logic [7:0]        d4_req_opcode;
    logic [63:0]       d4_req_in1, d4_req_in2;
    logic [9:0]        d4_req_sr_bit;
    logic [5:0]        d4_req_sr_cont;
    logic [31:0]       d4_rsp_data, d4_alu_in1, d4_alu_in2, d4_alu_out;
    logic [3:0]        d4_alu_opcode;
    logic [4:0]        d4_alu_sr_bit;
    logic [2:0]        d4_alu_sr_cont;
    logic              d4_busy;

    // Stand-in for the shared ALU: purely combinational.
    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sb,
                                          input logic [2:0] sc);
        case (op)
            4'd0:   return a + b;
            4'd1:   return a - b;
            OP_MUL: return a * b;
            4'd3:   return a & b;
            4'd4:   return a | b;
            4'd5:   return a ^ b;
            4'd6: begin
                case (sc)
                    3'd0:    return a << sb;
                    3'd1:    return a >> sb;
                    3'd2:    return 32'($signed(a) >>> sb);
                    default: return a ^ {27'd0, sb};
                endcase
            end
            default: return b;
        endcase
    endfunction

    assign alu_out    = alu_f(alu_opcode, alu_in1, alu_in2, alu_sr_bit, alu_sr_cont);
    assign d4_alu_out = alu_f(d4_alu_opcode, d4_alu_in1, d4_alu_in2, d4_alu_sr_bit, d4_alu_sr_cont);

    alu_req_arbiter #(.NREQ(NREQ), .ALU_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_in1(req_in1), .req_in2(req_in2),
        .req_sr_bit(req_sr_bit), .req_sr_cont(req_sr_cont), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data), .alu_opcode(alu_opcode),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_sr_bit(alu_sr_bit),
        .alu_sr_cont(alu_sr_cont), .alu_out(alu_out), .busy(busy)
    );

    alu_req_arbiter #(.NREQ(2), .ALU_LAT(4)) dut4 (
        .clk(clk), .rst_n(d4_rst_n), .req_valid(d4_req_valid), .req_ready(d4_req_ready),
        .req_opcode(d4_req_opcode), .req_in1(d4_req_in1), .req_in2(d4_req_in2),
        .req_sr_bit(d4_req_sr_bit), .req_sr_cont(d4_req_sr_cont), .rsp_valid(d4_rsp_valid),
        .rsp_ready(d4_rsp_ready), .rsp_data(d4_rsp_data), .alu_opcode(d4_alu_opcode),
        .alu_in1(d4_alu_in1), .alu_in2(d4_alu_in2), .alu_sr_bit(d4_alu_sr_bit),
        .alu_sr_cont(d4_alu_sr_cont), .alu_out(d4_alu_out), .busy(d4_busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Transaction-level model: one outstanding op, accepted at cycle m_acc,
    // response due from cycle m_acc+LAT+1 until the granted requester takes it.
    bit          m_act;
    int          m_g, m_acc, m_ptr, cyc;
    logic [3:0]  m_op;
    logic [31:0] m_a, m_b;
    logic [4:0]  m_sb;
    logic [2:0]  m_sc;
    bit          acc_ev [NREQ];
    int          grants [$];

    function automatic int win(input logic [NREQ-1:0] v);
        int w;
        w = -1;
`ifdef ALU_ARB_RR_EN
        for (int k = 1; k <= NREQ; k++)
            if (w < 0 && v[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
`else
        for (int k = 0; k < NREQ; k++)
            if (w < 0 && v[k]) w = k;
`endif
        return w;
    endfunction

    task automatic check_outputs();
        logic [NREQ-1:0] er, ev;
        bit resp;
        int w;
        resp = m_act && (cyc >= m_acc + LAT + 1);
        er = '0;
        w = win(req_valid);
        if (!m_act && rst_n && w >= 0) er[w] = 1'b1;
        ev = '0;
        if (resp) ev[m_g] = 1'b1;
        chk("req_ready", req_ready, er);
        chk("rsp_valid", rsp_valid, ev);
        chk("busy", busy, m_act);
        chk("alu_opcode", alu_opcode, m_op);
        chk("alu_in1", alu_in1, m_a);
        chk("alu_in2", alu_in2, m_b);
        chk("alu_sr", {alu_sr_bit, alu_sr_cont}, {m_sb, m_sc});
        if (resp) chk("rsp_data", rsp_data, alu_f(m_op, m_a, m_b, m_sb, m_sc));
    endtask

    task automatic update_model();
        int w;
        if (!rst_n) begin
            m_act = 0; m_ptr = NREQ-1;
            m_op = '0; m_a = '0; m_b = '0; m_sb = '0; m_sc = '0;
        end else if (!m_act) begin
            w = win(req_valid);
            if (w >= 0) begin
                m_act = 1; m_g = w; m_acc = cyc; m_ptr = w;
                m_op = req_opcode[w*4 +: 4];
                m_a  = req_in1[w*32 +: 32];
                m_b  = req_in2[w*32 +: 32];
                m_sb = req_sr_bit[w*5 +: 5];
                m_sc = req_sr_cont[w*3 +: 3];
                grants.push_back(w);
                acc_ev[w] = 1;
            end
        end else if (cyc >= m_acc + LAT + 1 && rsp_ready[m_g]) begin
            m_act = 0;
        end
        cyc++;
    endtask

    task automatic cycle();
        #1 check_outputs();
        @(posedge clk);
        update_model();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] sb, input logic [2:0] sc);
        req_opcode[i*4 +: 4]   = op;
        req_in1[i*32 +: 32]    = a;
        req_in2[i*32 +: 32]    = b;
        req_sr_bit[i*5 +: 5]   = sb;
        req_sr_cont[i*3 +: 3]  = sc;
    endtask

    task automatic drain();
        int n;
        req_valid = '0; rsp_ready = '1; n = 0;
        while (m_act && n < 20) begin cycle(); n++; end
        chk("drain_idle", busy, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        bit pend [NREQ];
        int n, g0, lat;
        logic [63:0] prod;

        m_act = 0; m_ptr = NREQ-1; cyc = 0; m_g = 0; m_acc = 0;
        m_op = '0; m_a = '0; m_b = '0; m_sb = '0; m_sc = '0;
        foreach (acc_ev[i]) acc_ev[i] = 0;
        rst_n = 1'b0; req_valid = '1; rsp_ready = '0;
        req_opcode = '0; req_in1 = '0; req_in2 = '0; req_sr_bit = '0; req_sr_cont = '0;
        d4_rst_n = 1'b0; d4_req_valid = '0; d4_rsp_ready = '0; d4_req_opcode = '0;
        d4_req_in1 = '0; d4_req_in2 = '0; d4_req_sr_bit = '0; d4_req_sr_cont = '0;

        // Reset held 3 clocks with both requesters valid.
        @(posedge clk); update_model(); @(negedge clk);
        cycle(); cycle();
        chk("reset_req_ready", req_ready, 2'b00);
        chk("reset_rsp_valid", rsp_valid, 2'b00);
        chk("reset_busy", busy, 1'b0);
        chk("reset_rsp_data", rsp_data, 32'd0);

        // Single multiply from requester 0.
        rst_n = 1'b1; req_valid = 2'b01;
        set_req(0, OP_MUL, 32'd7, 32'd6, 5'd0, 3'd0);
        #1 chk("mul_ready", req_ready, 2'b01);
        cycle();
        req_valid = 2'b00;
        chk("mul_lat_n1", rsp_valid, 2'b00);
        cycle();
        chk("mul_rsp_valid", rsp_valid, 2'b01);
        chk("mul_rsp_data", rsp_data, 32'd42);
        repeat (3) cycle();
        chk("mul_hold_valid", rsp_valid, 2'b01);
        chk("mul_hold_data", rsp_data, 32'd42);
        rsp_ready = 2'b01;
        cycle();
        chk("mul_done_busy", busy, 1'b0);

        // Contention from a fresh reset.
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
        set_req(0, 4'd0, 32'd100, 32'd5, 5'd0, 3'd0);
        set_req(1, 4'd1, 32'd100, 32'd5, 5'd0, 3'd0);
        req_valid = 2'b11; rsp_ready = 2'b11;
        g0 = grants.size(); n = 0;
        while (grants.size() < g0 + 4 && n < 60) begin cycle(); n++; end
        chk("contention_count", grants.size() - g0, 4);
        for (int k = 0; k < 4; k++) begin
            if (grants.size() > g0 + k) begin
`ifdef ALU_ARB_RR_EN
                chk("contention_grant", grants[g0+k], k % 2);
`else
                chk("contention_grant", grants[g0+k], 0);
`endif
            end
        end
        drain();

        // Reset one cycle after accept: that op must vanish.
        req_valid = 2'b01; rsp_ready = 2'b11;
        set_req(0, 4'd0, 32'd100, 32'd23, 5'd0, 3'd0);
        cycle();
        rst_n = 1'b0; req_valid = 2'b00;
        cycle();
        rst_n = 1'b1;
        repeat (8) begin cycle(); chk("abort_no_rsp", rsp_valid, 2'b00); end
        set_req(1, 4'd5, 32'hF0F0_0000, 32'h0000_0F0F, 5'd0, 3'd0);
        req_valid = 2'b10;
        cycle();
        req_valid = 2'b00; rsp_ready = 2'b00; n = 0;
        while (rsp_valid == 2'b00 && n < 10) begin cycle(); n++; end
        chk("post_abort_valid", rsp_valid, 2'b10);
        chk("post_abort_data", rsp_data, 32'hF0F0_0F0F);
        drain();

        // Stray rsp_ready on the non-granted bit.
        rsp_ready = 2'b00; req_valid = 2'b01;
        set_req(0, 4'd4, 32'h0000_00F0, 32'h0000_000F, 5'd0, 3'd0);
        cycle();
        req_valid = 2'b00;
        cycle();
        rsp_ready = 2'b10;
        repeat (3) begin
            cycle();
            chk("stray_valid", rsp_valid, 2'b01);
            chk("stray_busy", busy, 1'b1);
        end
        chk("stray_data", rsp_data, 32'h0000_00FF);
        rsp_ready = 2'b01;
        cycle();
        chk("stray_release", rsp_valid, 2'b00);

        // ALU_LAT=4 instance: requester 1 multiply.
        d4_rst_n = 1'b0; cycle(); cycle();
        d4_rst_n = 1'b1;
        d4_req_opcode[7:4] = OP_MUL;
        d4_req_in1[63:32]  = 32'd3479807;
        d4_req_in2[63:32]  = 32'd312578093;
        d4_req_valid = 2'b10;
        #1 chk("lat4_ready", d4_req_ready, 2'b10);
        cycle();
        d4_req_valid = 2'b00; lat = 1;
        while (d4_rsp_valid == 2'b00 && lat < 20) begin cycle(); lat++; end
        prod = 64'd3479807 * 64'd312578093;
        chk("lat4_latency", lat, 5);
        chk("lat4_valid", d4_rsp_valid, 2'b10);
        chk("lat4_data", d4_rsp_data, prod[31:0]);

        // Randomised traffic with occasional resets.
        drain();
        foreach (pend[i]) begin pend[i] = 0; acc_ev[i] = 0; end
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (acc_ev[i]) pend[i] = 0;
                acc_ev[i] = 0;
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1;
                    set_req(i, ($urandom_range(0, 3) == 0) ? OP_MUL : 4'($urandom_range(0, 15)),
                            $urandom, $urandom, 5'($urandom), 3'($urandom));
                end
                req_valid[i] = pend[i];
            end
            rsp_ready = NREQ'($urandom);
            rst_n = ($urandom_range(0, 60) != 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
